// File: rtl/urv_muldiv_seq.sv
// Iterative RV32M multiply/divide unit for the uRV execute stage; holds the stage via
// x_stall_req_o while a shared shift-add / restoring-divide datapath retires B bits per cycle.
module urv_muldiv_seq #(
  parameter int unsigned g_width          = 32,
  parameter int unsigned g_bits_per_cycle = 1,
  parameter int unsigned g_with_div       = 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               x_stall_i,
  input  logic               x_kill_i,
  output logic               x_stall_req_o,
  input  logic               d_valid_i,
  input  logic               d_is_multiply_i,
  input  logic               d_is_divide_i,
  input  logic [2:0]         d_fun_i,
  input  logic [g_width-1:0] d_rs1_i,
  input  logic [g_width-1:0] d_rs2_i,
  output logic [g_width-1:0] x_rd_o,
  output logic               x_busy_o
);

  localparam int unsigned W     = g_width;
  localparam int unsigned B     = g_bits_per_cycle;
  localparam int unsigned N     = W / B;
  localparam int unsigned CW    = (N > 1) ? $clog2(N) : 1;
  localparam bit          DivEn = (g_with_div != 0);

  typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_e;

  state_e          r_state;
  logic [2:0]      r_fun;
  logic            r_neg1;
  logic            r_neg2;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [2*W-1:0]  r_acc;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_rd;
  logic            r_busy;

  logic            w_start;
  logic            w_start_div;
  logic            w_s1;
  logic            w_s2;
  logic            w_neg1;
  logic            w_neg2;
  logic [W-1:0]    w_abs1;
  logic [W-1:0]    w_abs2;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_fast;
  logic [W-1:0]    w_fast_rd;
  logic [W+B-1:0]  w_pp;
  logic [W+B-1:0]  w_sum;
  logic [W:0]      w_trial;
  logic [W-1:0]    w_rem;
  logic [W-1:0]    w_quo;
  logic [W-1:0]    w_dvd;
  logic [2*W-1:0]  w_acc_nxt;
  logic [W-1:0]    w_a_nxt;
  logic [W-1:0]    w_b_nxt;
  logic [2*W-1:0]  w_prod;
  logic [W-1:0]    w_quo_fix;
  logic [W-1:0]    w_rem_fix;
  logic [W-1:0]    w_sel;

  assign w_start = (r_state == StIdle) && d_valid_i && !x_kill_i &&
                   (d_is_multiply_i || (d_is_divide_i && DivEn));
  assign w_start_div = w_start && !d_is_multiply_i;

  // rs1 signed for MULH/MULHSU/DIV/REM, rs2 signed for MULH/DIV/REM
  assign w_s1 = (d_fun_i == 3'b001) || (d_fun_i == 3'b010) ||
                (d_fun_i == 3'b100) || (d_fun_i == 3'b110);
  assign w_s2 = (d_fun_i == 3'b001) || (d_fun_i == 3'b100) || (d_fun_i == 3'b110);
  assign w_neg1 = w_s1 && d_rs1_i[W-1];
  assign w_neg2 = w_s2 && d_rs2_i[W-1];
  assign w_abs1 = w_neg1 ? -d_rs1_i : d_rs1_i;
  assign w_abs2 = w_neg2 ? -d_rs2_i : d_rs2_i;

  assign w_div_zero = (d_rs2_i == '0);
  assign w_div_ovf  = !d_fun_i[0] && (d_rs1_i == {1'b1, {(W-1){1'b0}}}) && (d_rs2_i == '1);
  assign w_fast     = w_start_div && (w_div_zero || w_div_ovf);
  // Overflowed quotient equals the dividend (MIN); divide-by-zero remainder is the dividend
  assign w_fast_rd  = d_fun_i[1] ? (w_div_zero ? d_rs1_i : '0)
                                 : (w_div_zero ? '1 : d_rs1_i);

  always_comb begin
    w_pp    = '0;
    w_trial = '0;
    w_rem   = r_acc[2*W-1:W];
    w_quo   = r_acc[W-1:0];
    w_dvd   = r_a;
    for (int unsigned j = 0; j < B; j++) begin
      if (r_b[j]) w_pp = w_pp + ({{B{1'b0}}, r_a} << j);
    end
    w_sum = {{B{1'b0}}, r_acc[2*W-1:W]} + w_pp;
    for (int unsigned j = 0; j < B; j++) begin
      w_trial = {w_rem, w_dvd[W-1]};
      w_dvd   = w_dvd << 1;
      if (w_trial >= {1'b0, r_b}) begin
        w_rem = w_trial[W-1:0] - r_b;
        w_quo = {w_quo[W-2:0], 1'b1};
      end else begin
        w_rem = w_trial[W-1:0];
        w_quo = {w_quo[W-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    w_acc_nxt = {w_sum, r_acc[W-1:B]};
    w_a_nxt   = r_a;
    w_b_nxt   = r_b >> B;
    if (DivEn && r_fun[2]) begin
      w_acc_nxt = {w_rem, w_quo};
      w_a_nxt   = w_dvd;
      w_b_nxt   = r_b;
    end
  end

  assign w_prod    = (r_neg1 ^ r_neg2) ? -r_acc : r_acc;
  assign w_quo_fix = (r_neg1 ^ r_neg2) ? -r_acc[W-1:0] : r_acc[W-1:0];
  assign w_rem_fix = r_neg1 ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

  always_comb begin
    w_sel = '0;
    unique case (r_fun)
      3'b000:                 w_sel = w_prod[W-1:0];
      3'b001, 3'b010, 3'b011: w_sel = w_prod[2*W-1:W];
      3'b100, 3'b101:         w_sel = w_quo_fix;
      default:                w_sel = w_rem_fix;
    endcase
  end

  assign x_stall_req_o = rst_n_i && !x_kill_i &&
                         (w_start || (r_state == StBusy) || (r_state == StFix));
  assign x_rd_o   = r_rd;
  assign x_busy_o = r_busy;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= StIdle;
      r_fun   <= '0;
      r_neg1  <= 1'b0;
      r_neg2  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_busy  <= 1'b0;
    end else if (x_kill_i) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_fun  <= d_fun_i;
            r_neg1 <= w_neg1;
            r_neg2 <= w_neg2;
            r_a    <= w_abs1;
            r_b    <= w_abs2;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (w_fast) begin
              r_rd    <= w_fast_rd;
              r_state <= StDone;
            end else begin
              r_state <= StBusy;
            end
          end else if (d_valid_i && d_is_divide_i && !d_is_multiply_i && !DivEn) begin
            r_rd <= '0;
          end
        end
        StBusy: begin
          r_acc <= w_acc_nxt;
          r_a   <= w_a_nxt;
          r_b   <= w_b_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) r_state <= StFix;
        end
        StFix: begin
          r_rd    <= w_sel;
          r_state <= StDone;
        end
        default: begin
          if (!x_stall_i) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/urv_muldiv_seq.md
Name: urv_muldiv_seq

Overview:
- Iterative multiply/divide unit for the uRV execute stage; implements all eight RV32M functions (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) in one shared datapath.
- Holds the execute stage through the existing stall/kill protocol while it iterates.
- Parametrised in operand width and bits retired per cycle, trading area against latency.
- Handles mid-operation kill and the RISC-V divide corner cases.

Parameters:
- g_width, 32, operand/result width W; must be a multiple of g_bits_per_cycle.
- g_bits_per_cycle, 1, bits B retired per iteration cycle (1, 2 or 4); iteration count N = W/B.
- g_with_div, 1, 0 removes the divider: divide ops never stall and return 0.

Ports:
- clk_i  in  1  clock; only clock in the block.
- rst_n_i  in  1  reset, asynchronous, active-low.
- x_stall_i  in  1  execute stage stalled, from the pipeline controller.
- x_kill_i  in  1  execute-stage instruction killed.
- x_stall_req_o  out  1  request that the execute stage be held; combinational.
- d_valid_i  in  1  valid instruction in execute.
- d_is_multiply_i  in  1  instruction is MUL*.
- d_is_divide_i  in  1  instruction is DIV*/REM*.
- d_fun_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- d_rs1_i  in  W  operand 1 (multiplicand / dividend).
- d_rs2_i  in  W  operand 2 (multiplier / divisor).
- x_rd_o  out  W  result; registered; valid in state DONE.
- x_busy_o  out  1  state != IDLE; registered; for debug.

Behaviour:
- Reset (rst_n_i low, asynchronous): state IDLE, x_rd_o=0, x_busy_o=0, all internal registers 0. x_stall_req_o is 0 while reset is asserted.
- Start condition: state IDLE && d_valid_i && (d_is_multiply_i || (d_is_divide_i && g_with_div)) && !x_kill_i.
  - x_stall_i is ignored for start, because our own request drives it.
- States: IDLE, BUSY, FIX, DONE.
- IDLE: on start, x_stall_req_o=1 in the same cycle. On the clock edge:
  - latch funct3;
  - latch the operand signs: rs1 signed for MULH/MULHSU/DIV/REM, rs2 signed for MULH/DIV/REM;
  - latch the absolute values;
  - clear the accumulator and the iteration counter;
  - go to BUSY.
- IDLE fast path (divide only), taken instead of BUSY; state goes straight to DONE:
  - divisor==0: quotient=all-ones, remainder=rs1 unmodified.
  - signed overflow (DIV/REM, rs1=MIN, rs2=-1): quotient=MIN, remainder=0.
- BUSY: x_stall_req_o=1; N cycles. Each cycle retires B bits:
  - multiply: radix-2^B shift-add on the unsigned magnitudes into a 2W-bit product;
  - divide: B restoring steps on the magnitudes into quotient and remainder.
  - When the counter reaches N-1, go to FIX.
- FIX: x_stall_req_o=1; one cycle. Applies two's-complement sign correction:
  - product negated if the operand signs differ;
  - quotient negated if the signs differ;
  - remainder takes the dividend's sign.
  - Selects the word:
    - MUL: low W bits;
    - MULH/MULHSU/MULHU: high W bits;
    - DIV/DIVU: quotient;
    - REM/REMU: remainder.
  - Registers the selected word into x_rd_o; go to DONE.
- DONE: x_stall_req_o=0; x_rd_o holds its value.
  - Stay in DONE while x_stall_i=1, i.e. held by another stall source; the result is held with no restart.
  - Go to IDLE on the first cycle with x_stall_i=0, when the instruction leaves execute.
  - The next instruction is evaluated for start only from IDLE, so there is never a back-to-back restart of the same instruction.
- Latency, measured as stall-request cycles including the issue cycle:
  - normal case: N+2 cycles (W=32: B=1 gives 34, B=2 gives 18, B=4 gives 10);
  - divide fast path: 1 cycle.
- Kill: x_kill_i=1 in any state forces x_stall_req_o=0 combinationally and returns the state to IDLE on the next edge; x_rd_o is not updated.
- Simultaneous kill and start in IDLE: kill wins; no start.
- Reset mid-operation: immediate return to reset values; no partial result survives.
- Non-M instructions and d_valid_i=0: no effect; x_stall_req_o=0.
- g_with_div=0: divide ops produce no start and no stall; x_rd_o=0 for them.
- All arithmetic is on W-bit operands with W+1/2W-bit internals; no overflow flags.

Test Plan:
- W=32, B=1, MUL 7*-3 -> x_stall_req_o high exactly 34 cycles, then x_rd_o=0xFFFFFFEB in DONE.
- W=32, B=4, MULH 0x80000000*0x80000000 -> 10 stall cycles, x_rd_o=0x40000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- DIV -7/2 -> x_rd_o=0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- DIV 5/0 -> 1 stall cycle, x_rd_o=0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
- Kill at BUSY cycle 5 -> x_stall_req_o=0 that cycle, IDLE next cycle; a following MUL 3*4 takes the full latency and gives 12.
- DONE with x_stall_i held 3 cycles -> x_rd_o stable, no new stall request; IDLE after x_stall_i drops. Assert rst_n_i mid-BUSY -> all outputs 0 immediately.
